// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // Default queue entry for the 32-bit PC / 32-bit instruction configuration.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-2 prefetch FIFO; flush clears it and wins over enqueue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  entry_t        enq_data,
  input  logic          deq,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fills the prefetch queue from the
// combinational ROM and hands {pc, instr} to decode over valid/ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int                         DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic                     misalign,
  output logic [31:0]              fetch_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [CW-1:0]            count;
  logic                     deq;
  logic                     fetch;
  entry_t                   enq_data;
  entry_t                   head;

  assign mem_addr  = pc_q;
  assign out_valid = (count != '0);
  assign deq       = out_valid && out_ready;
  // A full queue may still accept when the head leaves in the same cycle.
  assign fetch     = (state == RUN) && !halt && !redirect_valid &&
                     ((count < DEPTH_C) || deq);
  assign enq_data  = '{pc: pc_q, instr: mem_rdata};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (fetch),
    .enq_data (enq_data),
    .deq      (deq),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head)
  );

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = halt ? HALTED : RUN;
      RUN:     if (halt) state_next = HALTED;
      HALTED:  if (!halt) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Redirect overrides both the sequential increment and a halted PC.
  always_comb begin
    pc_next = pc_q;
    if (redirect_valid)
      pc_next = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    else if (fetch)
      pc_next = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state    <= state_next;
      pc_q     <= pc_next;
      misalign <= redirect_valid && (|redirect_pc[1:0]);
      if (fetch) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small combinational ROM model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign       (misalign),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:  rom = 32'h0050_0093;
      32'h04:  rom = 32'h0010_0113;
      32'h08:  rom = 32'h0020_81B3;
      default: rom = 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  always_comb mem_rdata = rom(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    rst = 1'b0;

    // Straight-line fetch
    tick();  // edge 0: BOOT -> RUN
    check("boot_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("e1_valid", {31'b0, out_valid}, 32'd1);
    check("e1_pc", out_pc, 32'h00);
    check("e1_instr", out_instr, 32'h0050_0093);
    tick();
    check("e2_pc", out_pc, 32'h04);
    check("e2_instr", out_instr, 32'h0010_0113);
    tick();
    check("e3_pc", out_pc, 32'h08);
    check("e3_instr", out_instr, 32'h0020_81B3);
    check("e3_count", fetch_count, 32'd3);

    // Restart at 0 with backpressure so the queue fills with 0x00/0x04
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check("bp_flush_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("bp_addr", mem_addr, 32'h08);
    check("bp_pc", out_pc, 32'h00);
    check("bp_count", fetch_count, 32'd5);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_pc", out_pc, 32'h04);
    check("bp_rel1_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_rel2_pc", out_pc, 32'h08);
    check("bp_rel2_instr", out_instr, 32'h0020_81B3);
    check("bp_rel2_count", fetch_count, 32'd7);

    // Fill queue, then redirect while full
    out_ready = 1'b0;
    tick();
    check("full_addr", mem_addr, 32'h10);
    check("full_pc", out_pc, 32'h08);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("redir_valid", {31'b0, out_valid}, 32'd0);
    check("redir_addr", mem_addr, 32'h40);
    check("redir_misalign", {31'b0, misalign}, 32'd0);
    tick();
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'hC0DE_0040);
    check("redir_misalign2", {31'b0, misalign}, 32'd0);
    check("redir_count", fetch_count, 32'd8);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_addr", mem_addr, 32'h40);
    tick();
    check("mis_clear", {31'b0, misalign}, 32'd0);
    check("mis_pc", out_pc, 32'h40);
    check("mis_count", fetch_count, 32'd9);

    // Halt: no enqueue, queue drains, redirect still moves the PC
    halt = 1'b1; out_ready = 1'b0;
    tick();
    check("halt_hold_valid", {31'b0, out_valid}, 32'd1);
    check("halt_count1", fetch_count, 32'd9);
    out_ready = 1'b1;
    tick();
    check("halt_drain", {31'b0, out_valid}, 32'd0);
    tick();
    check("halt_count2", fetch_count, 32'd9);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("halt_redir_addr", mem_addr, 32'h80);
    check("halt_redir_valid", {31'b0, out_valid}, 32'd0);
    check("halt_redir_count", fetch_count, 32'd9);
    halt = 1'b0;
    tick();
    check("resume_wait_valid", {31'b0, out_valid}, 32'd0);
    check("resume_wait_addr", mem_addr, 32'h80);
    tick();
    check("resume_pc", out_pc, 32'h80);
    check("resume_valid", {31'b0, out_valid}, 32'd1);
    check("resume_count", fetch_count, 32'd10);

    // Async reset mid-stream with PC at 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h1C;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("pre_rst_addr", mem_addr, 32'h20);
    check("pre_rst_pc", out_pc, 32'h1C);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_pc", out_pc, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("reboot_valid0", {31'b0, out_valid}, 32'd0);
    tick();
    check("reboot_valid1", {31'b0, out_valid}, 32'd1);
    check("reboot_pc", out_pc, 32'h0);
    check("reboot_count", fetch_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
